// File: rtl/logic_ops_pkg.sv
// -----------------------------------------------------------------------------
// logic_ops_pkg
// Shared types and constants for the byte-serial MIPS32 logic controller.
//   op_t    : 2-bit logic operation code (AND/OR/XOR/NOR)
//   state_t : controller FSM state (IDLE/RUN/DONE)
//   BYTE_W  : width of one logic slice
// -----------------------------------------------------------------------------
package logic_ops_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/byte_logic_unit.sv
// -----------------------------------------------------------------------------
// byte_logic_unit
// Purely combinational 8-bit logic slice shared by all byte positions.
// Ports:
//   a, b : byte operands
//   op   : operation code (op_t)
//   z    : byte result; NOR is formed as ~(a | b)
// -----------------------------------------------------------------------------
module byte_logic_unit
  import logic_ops_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  op_t               op,
  output logic [BYTE_W-1:0] z
);

  always_comb begin
    // NOTE: default assignment first so every path drives z and no latch is inferred.
    z = '0;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_XOR:  z = a ^ b;
      OP_NOR:  z = ~(a | b);
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/byte_serial_logic_ctrl.sv
// -----------------------------------------------------------------------------
// byte_serial_logic_ctrl
// Multi-cycle controller computing a (8*NBYTES)-bit bitwise AND/OR/XOR/NOR
// through one shared 8-bit slice, one byte per clock, LSB byte first.
//
// Parameters:
//   NBYTES   : bytes per operand (>= 2)
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start_i  : request, accepted in IDLE or DONE only
//   op_i     : operation code, sampled with start_i
//   a_i, b_i : operands, sampled with start_i
//   busy_o   : high while in RUN
//   done_o   : one-cycle pulse when result_o is complete
//   result_o : result register
//   zero_o   : result-is-zero flag (only when BSL_ZERO_FLAG_EN is defined)
//
// Build option:
//   BSL_ZERO_FLAG_EN : adds the zero_o port and its accumulator.
// -----------------------------------------------------------------------------
module byte_serial_logic_ctrl
  import logic_ops_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [1:0]              op_i,
  input  logic [BYTE_W*NBYTES-1:0] a_i,
  input  logic [BYTE_W*NBYTES-1:0] b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [BYTE_W*NBYTES-1:0] result_o
`ifdef BSL_ZERO_FLAG_EN
  ,
  output logic                    zero_o
`endif
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state;
  logic [IDX_W-1:0]  byte_idx;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  op_t               op_q;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] z_byte;

  // Byte mux: select the current byte of the latched operands.
  assign a_byte = a_q[int'(byte_idx) * BYTE_W +: BYTE_W];
  assign b_byte = b_q[int'(byte_idx) * BYTE_W +: BYTE_W];

  byte_logic_unit u_slice (
    .a  (a_byte),
    .b  (b_byte),
    .op (op_q),
    .z  (z_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the result and operand registers are plain flops (not a memory
      // array), so they are reset like any other state.
      state    <= ST_IDLE;
      byte_idx <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      result_o <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
`ifdef BSL_ZERO_FLAG_EN
      zero_o   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the
      // pre-edge values of the others regardless of statement order.
      case (state)
        ST_IDLE, ST_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            op_q     <= op_t'(op_i);
            byte_idx <= '0;
            busy_o   <= 1'b1;
            state    <= ST_RUN;
`ifdef BSL_ZERO_FLAG_EN
            zero_o   <= 1'b1;
`endif
          end else begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_RUN: begin
          // start_i is deliberately not looked at here.
          result_o[int'(byte_idx) * BYTE_W +: BYTE_W] <= z_byte;
`ifdef BSL_ZERO_FLAG_EN
          if (z_byte != '0) zero_o <= 1'b0;
`endif
          if (byte_idx == LAST_IDX) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_DONE;
          end else begin
            byte_idx <= byte_idx + IDX_W'(1);
          end
        end

        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_logic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_logic_ctrl
// Self-checking bench for byte_serial_logic_ctrl (NBYTES=4 main instance and
// an NBYTES=2 instance). Expected results are queued at request time and
// popped when done_o is observed. Zero-flag checks exist only when
// BSL_ZERO_FLAG_EN is defined.
// -----------------------------------------------------------------------------
module tb_byte_serial_logic_ctrl;
  import logic_ops_pkg::*;

  localparam int NB  = 4;
  localparam int W   = 32;
  localparam int W2  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  result;

  logic          start2;
  logic [1:0]    op2;
  logic [W2-1:0] a2, b2;
  logic          busy2, done2;
  logic [W2-1:0] result2;

`ifdef BSL_ZERO_FLAG_EN
  logic zero, zero2;
`endif

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  byte_serial_logic_ctrl #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
`ifdef BSL_ZERO_FLAG_EN
    ,
    .zero_o   (zero)
`endif
  );

  byte_serial_logic_ctrl #(.NBYTES(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start2),
    .op_i     (op2),
    .a_i      (a2),
    .b_i      (b2),
    .busy_o   (busy2),
    .done_o   (done2),
    .result_o (result2)
`ifdef BSL_ZERO_FLAG_EN
    ,
    .zero_o   (zero2)
`endif
  );

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Drive a request; it is accepted at the next rising edge. Operands are
  // scrambled afterwards so an unlatched operand path shows up as a wrong result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    a     = ~x;
    b     = ~y;
  endtask

  // Count falling edges after the accept until done, bounded.
  task automatic wait_done(output int lat, output int busy_n, output bit seen);
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0; op  = '0; a  = '0; b  = '0;
    start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (result !== '0 || result2 !== '0) begin
      failures++;
      $display("FAIL reset_result: got %h/%h expected 0/0", result, result2);
    end
`ifdef BSL_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_zero: got %b expected 0", zero);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_or;
    int lat, bn; bit seen; logic [W-1:0] e;
    exp_q.push_back(32'hFFFF_00FF);
    issue(2'b01, 32'hF0F0_0000, 32'h0F0F_00FF);
    wait_done(lat, bn, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != NB + 1 || bn != NB) begin
      failures++;
      $display("FAIL or_timing: seen=%0d latency=%0d busy_cycles=%0d expected 1 %0d %0d",
               seen, lat, bn, NB + 1, NB);
    end
    checks++;
    if (result !== e) begin
      failures++;
      $display("FAIL or_result: got %h expected %h", result, e);
    end
`ifdef BSL_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin
      failures++;
      $display("FAIL or_zero: got %b expected 0", zero);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== e) begin
      failures++;
      $display("FAIL or_after_done: done=%b busy=%b result=%h expected 0 0 %h",
               done, busy, result, e);
    end
  endtask

  task automatic test_nor;
    int lat, bn; bit seen; logic [W-1:0] e;
    exp_q.push_back(32'h0000_0000);
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0000);
    wait_done(lat, bn, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || result !== e) begin
      failures++;
      $display("FAIL nor_result: seen=%0d got %h expected %h", seen, result, e);
    end
`ifdef BSL_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL nor_zero: got %b expected 1", zero);
    end
`endif
  endtask

  task automatic test_xor_ignore;
    int done_cnt, busy_cnt, done_at;
    exp_q.push_back(32'h0000_0000);
    issue(2'b10, 32'h1234_5678, 32'h1234_5678);
    // Hold start high with different operands while the DUT is in RUN.
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h0;
    done_cnt = 0; busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = i; end
      if (i == 3) start = 1'b0;
    end
    checks++;
    if (done_cnt != 1 || done_at != NB + 1 || busy_cnt != NB) begin
      failures++;
      $display("FAIL xor_ignore_timing: done_pulses=%0d at=%0d busy_cycles=%0d expected 1 %0d %0d",
               done_cnt, done_at, busy_cnt, NB + 1, NB);
    end
    checks++;
    if (result !== exp_q[0]) begin
      failures++;
      $display("FAIL xor_ignore_result: got %h expected %h", result, exp_q[0]);
    end
    void'(exp_q.pop_front());
`ifdef BSL_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL xor_ignore_zero: got %b expected 1", zero);
    end
`endif
  endtask

  task automatic test_reset_midrun;
    int lat, bn; bit seen; logic [W-1:0] e;
    issue(2'b00, 32'hDEAD_BEEF, 32'h0FF0_F00F);
    repeat (3) @(negedge clk);
    // Two bytes written over the previous all-zero result.
    checks++;
    if (result !== 32'h0000_B00F || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_partial: result=%h busy=%b expected 0000b00f 1", result, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL midrun_async_reset: busy=%b done=%b result=%h expected 0 0 0",
               busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0EA0_B00F);
    issue(2'b00, 32'hDEAD_BEEF, 32'h0FF0_F00F);
    wait_done(lat, bn, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != NB + 1 || result !== e) begin
      failures++;
      $display("FAIL midrun_rerun: seen=%0d latency=%0d result=%h expected 1 %0d %h",
               seen, lat, result, NB + 1, e);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn; bit seen; logic [W-1:0] e;
    exp_q.push_back(32'h0000_0003);
    issue(2'b01, 32'h1, 32'h2);
    wait_done(lat, bn, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || result !== e) begin
      failures++;
      $display("FAIL b2b_first: seen=%0d got %h expected %h", seen, result, e);
    end
    // Still in the done cycle: request again right away.
    exp_q.push_back(32'h0000_000F);
    issue(2'b00, 32'hFF, 32'h0F);
    wait_done(lat, bn, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || lat != NB + 1 || bn != NB) begin
      failures++;
      $display("FAIL b2b_second_timing: seen=%0d latency=%0d busy_cycles=%0d expected 1 %0d %0d",
               seen, lat, bn, NB + 1, NB);
    end
    checks++;
    if (result !== e) begin
      failures++;
      $display("FAIL b2b_second_result: got %h expected %h", result, e);
    end
  endtask

  task automatic test_random;
    int lat, bn; bit seen; logic [W-1:0] e, x, y; logic [1:0] o;
    for (int n = 0; n < 8; n++) begin
      o = 2'(n % 4);
      x = $urandom;
      y = $urandom;
      exp_q.push_back(model(o, x, y));
      issue(o, x, y);
      wait_done(lat, bn, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != NB + 1 || result !== e) begin
        failures++;
        $display("FAIL random_%0d: op=%0d a=%h b=%h seen=%0d latency=%0d got %h expected %h",
                 n, o, x, y, seen, lat, result, e);
      end
`ifdef BSL_ZERO_FLAG_EN
      checks++;
      if (zero !== (e == '0)) begin
        failures++;
        $display("FAIL random_zero_%0d: got %b expected %b", n, zero, (e == '0));
      end
`endif
    end
  endtask

  task automatic test_nbytes2;
    int lat, bn; bit seen;
    start2 = 1'b1; op2 = 2'b10; a2 = 16'hAAAA; b2 = 16'hFFFF;
    @(posedge clk);
    #1;
    start2 = 1'b0; a2 = '0; b2 = '0;
    lat = 0; bn = 0; seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy2) bn++;
      if (done2) begin lat = i; seen = 1'b1; break; end
    end
    checks++;
    if (!seen || lat != 3 || bn != 2) begin
      failures++;
      $display("FAIL nb2_timing: seen=%0d latency=%0d busy_cycles=%0d expected 1 3 2",
               seen, lat, bn);
    end
    checks++;
    if (result2 !== 16'h5555) begin
      failures++;
      $display("FAIL nb2_result: got %h expected 5555", result2);
    end
`ifdef BSL_ZERO_FLAG_EN
    checks++;
    if (zero2 !== 1'b0) begin
      failures++;
      $display("FAIL nb2_zero: got %b expected 0", zero2);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_or();
    test_nor();
    test_xor_ignore();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    test_nbytes2();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
